// File: rtl/mips_debug_unit.sv
// UART debug controller for the pipelined MIPS: single-step with full state
// dump over the transmitter, or word-wise program load into instruction memory.
module mips_debug_unit #(
    parameter int              NB               = 32,
    parameter int              DATA_BITS        = 8,
    parameter int              NUMBER_REGISTERS = 32,
    parameter int              NUMBER_MEM_WORDS = 16,
    parameter logic [NB-1:0]   HALT_INSTRUCTION = 32'hFFFF_FFFF
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset,
    input  logic                                  i_uart_rx_ready,
    input  logic [DATA_BITS-1:0]                  i_uart_rx_data,
    input  logic                                  i_uart_tx_done,
    input  logic [NB-1:0]                         i_mips_pc,
    input  logic [NB-1:0]                         i_mips_register,
    input  logic [NB-1:0]                         i_mips_alu_result,
    input  logic [NB-1:0]                         i_mips_mem_data,
    output logic [$clog2(NUMBER_REGISTERS+1)-1:0] o_mips_register_number,
    output logic [NB-1:0]                         o_mips_memory_address,
    output logic [DATA_BITS-1:0]                  o_uart_tx_data,
    output logic                                  o_uart_tx_ready,
    output logic                                  o_step,
    output logic                                  o_instruction_write_enable,
    output logic [NB-1:0]                         o_instruction_address,
    output logic [NB-1:0]                         o_instruction_data
);
    localparam int RW = $clog2(NUMBER_REGISTERS + 1);
    localparam int MW = $clog2(NUMBER_MEM_WORDS + 1);
    localparam logic [DATA_BITS-1:0] CMD_STEP = DATA_BITS'(8'h73);
    localparam logic [DATA_BITS-1:0] CMD_LOAD = DATA_BITS'(8'h69);

    typedef enum logic [2:0] {IDLE, STEP, SEND, GAP, WAIT, LOAD} state_t;
    typedef enum logic [1:0] {PH_PC, PH_REG, PH_ALU, PH_MEM} phase_t;

    state_t               state;
    state_t               state_nxt;
    phase_t               phase;
    logic [NB-1:0]        send_buf;
    logic [NB-1:0]        load_word;
    logic [NB-1:0]        load_addr;
    logic [NB-1:0]        load_next;
    logic [1:0]           byte_cnt;
    logic                 wait_cnt;
    logic [RW-1:0]        reg_idx;
    logic [MW-1:0]        mem_idx;
    logic                 rx_prev;
    logic                 rx_rise;
    logic                 last_byte;
    logic                 last_reg;
    logic                 last_mem;
    logic [DATA_BITS-1:0] tx_byte;

    assign rx_rise   = i_uart_rx_ready & ~rx_prev;
    assign last_byte = (byte_cnt == 2'd3);
    assign last_reg  = (reg_idx == RW'(NUMBER_REGISTERS - 1));
    assign last_mem  = (mem_idx == MW'(NUMBER_MEM_WORDS - 1));
    assign load_next = {load_word[NB-DATA_BITS-1:0], i_uart_rx_data};

    assign o_step                 = (state == STEP);
    assign o_uart_tx_ready        = (state == SEND);
    assign o_uart_tx_data         = tx_byte;
    assign o_mips_register_number = reg_idx;
    assign o_mips_memory_address  = {{(NB-MW-2){1'b0}}, mem_idx, 2'b00};

    always_comb begin
        unique case (byte_cnt)
            2'd0: tx_byte = send_buf[NB-1 -: DATA_BITS];
            2'd1: tx_byte = send_buf[NB-1-DATA_BITS -: DATA_BITS];
            2'd2: tx_byte = send_buf[NB-1-2*DATA_BITS -: DATA_BITS];
            2'd3: tx_byte = send_buf[DATA_BITS-1:0];
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (i_uart_rx_ready) begin
                    if (i_uart_rx_data == CMD_STEP)      state_nxt = STEP;
                    else if (i_uart_rx_data == CMD_LOAD) state_nxt = LOAD;
                end
            end
            STEP: state_nxt = SEND;
            SEND: if (i_uart_tx_done) state_nxt = GAP;
            GAP: begin
                if (!last_byte) begin
                    state_nxt = SEND;
                end else begin
                    unique case (phase)
                        PH_PC:  state_nxt = WAIT;
                        PH_REG: state_nxt = last_reg ? SEND : WAIT;
                        PH_ALU: state_nxt = WAIT;
                        PH_MEM: state_nxt = last_mem ? IDLE : WAIT;
                    endcase
                end
            end
            WAIT: if (wait_cnt) state_nxt = SEND;
            LOAD: begin
                if (rx_rise && last_byte && load_next == HALT_INSTRUCTION)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            phase                      <= PH_PC;
            send_buf                   <= '0;
            load_word                  <= '0;
            load_addr                  <= '0;
            byte_cnt                   <= '0;
            wait_cnt                   <= 1'b0;
            reg_idx                    <= '0;
            mem_idx                    <= '0;
            rx_prev                    <= 1'b0;
            o_instruction_write_enable <= 1'b0;
            o_instruction_address      <= '0;
            o_instruction_data         <= '0;
        end else begin
            rx_prev                    <= i_uart_rx_ready;
            o_instruction_write_enable <= 1'b0;
            unique case (state)
                IDLE: byte_cnt <= '0;
                STEP: begin
                    send_buf <= i_mips_pc;
                    phase    <= PH_PC;
                end
                GAP: begin
                    if (!last_byte) begin
                        byte_cnt <= byte_cnt + 2'd1;
                    end else begin
                        byte_cnt <= '0;
                        wait_cnt <= 1'b0;
                        unique case (phase)
                            PH_PC: phase <= PH_REG;
                            PH_REG: begin
                                if (last_reg) begin
                                    phase    <= PH_ALU;
                                    send_buf <= i_mips_alu_result;
                                end else begin
                                    reg_idx <= reg_idx + RW'(1);
                                end
                            end
                            PH_ALU: phase <= PH_MEM;
                            PH_MEM: begin
                                if (last_mem) begin
                                    phase   <= PH_PC;
                                    reg_idx <= '0;
                                    mem_idx <= '0;
                                end else begin
                                    mem_idx <= mem_idx + MW'(1);
                                end
                            end
                        endcase
                    end
                end
                // Read data may lag the index by a cycle; latch on the second.
                WAIT: begin
                    wait_cnt <= ~wait_cnt;
                    if (wait_cnt)
                        send_buf <= (phase == PH_MEM) ? i_mips_mem_data
                                                      : i_mips_register;
                end
                LOAD: begin
                    if (rx_rise) begin
                        load_word <= load_next;
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (last_byte) begin
                            o_instruction_data         <= load_next;
                            o_instruction_address      <= load_addr;
                            o_instruction_write_enable <= 1'b1;
                            load_addr <= (load_next == HALT_INSTRUCTION)
                                         ? '0 : load_addr + NB'(4);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_debug_unit.sv
// Self-checking bench for mips_debug_unit: dump stream vs. a byte-queue model,
// program load vs. an expected-write queue, plus reset and abort cases.
module tb_mips_debug_unit;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] ALU  = 32'h0A1B_2C3D;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        tx_done = 1'b0;
    logic [31:0] pc;
    logic [31:0] reg_rd = '0;
    logic [31:0] alu;
    logic [31:0] mem_rd = '0;
    logic [5:0]  reg_num;
    logic [31:0] mem_addr;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        step;
    logic        we;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;

    always #5 clk = ~clk;

    mips_debug_unit dut (
        .i_clk                      (clk),
        .i_reset                    (rst_n),
        .i_uart_rx_ready            (rx_ready),
        .i_uart_rx_data             (rx_data),
        .i_uart_tx_done             (tx_done),
        .i_mips_pc                  (pc),
        .i_mips_register            (reg_rd),
        .i_mips_alu_result          (alu),
        .i_mips_mem_data            (mem_rd),
        .o_mips_register_number     (reg_num),
        .o_mips_memory_address      (mem_addr),
        .o_uart_tx_data             (tx_data),
        .o_uart_tx_ready            (tx_ready),
        .o_step                     (step),
        .o_instruction_write_enable (we),
        .o_instruction_address      (instr_addr),
        .o_instruction_data         (instr_data)
    );

    function automatic logic [31:0] reg_val(input int n);
        return 32'hC0DE_0000 ^ (32'(n) * 32'h0103_0507);
    endfunction

    function automatic logic [31:0] mem_val(input int n);
        return 32'h5A00_0000 + 32'(n) * 32'h0011_2233;
    endfunction

    // CPU-side read ports with one cycle of latency
    always @(posedge clk) begin
        reg_rd <= reg_val(int'(reg_num));
        mem_rd <= mem_val(int'(mem_addr[31:2]));
    end

    typedef struct {
        logic [7:0] b;
        int         kind;
        int         idx;
    } byte_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    byte_t exp_q[$];
    wr_t   wr_q[$];

    int checks = 0;
    int passes = 0;
    int bytes_seen = 0;
    int step_cycles = 0;
    int write_count = 0;
    logic [31:0] first_word = '0;
    logic [7:0]  cur_byte = '0;
    logic ready_prev = 1'b0;
    logic done_prev = 1'b0;
    logic step_prev = 1'b0;
    logic we_prev = 1'b0;
    logic done_hold = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_word(input logic [31:0] w, input int kind,
                             input int idx);
        for (int k = 3; k >= 0; k--) begin
            byte_t e;
            e.b = w[8*k +: 8];
            e.kind = kind;
            e.idx = idx;
            exp_q.push_back(e);
        end
    endtask

    task automatic build_dump(input logic [31:0] p);
        push_word(p, 0, 0);
        for (int r = 0; r < 32; r++) push_word(reg_val(r), 1, r);
        push_word(ALU, 2, 0);
        for (int m = 0; m < 16; m++) push_word(mem_val(m), 3, m);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        repeat (hold) @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_dump(input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || tx_ready) && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("dump_in_time", 32'(c < budget), 32'd1);
        @(negedge clk);
    endtask

    // Compare process and transmitter acknowledge model
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_ready && !ready_prev) begin
                bytes_seen++;
                if (bytes_seen <= 4) first_word = {first_word[23:0], tx_data};
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL extra_byte: got %h expected none", tx_data);
                end else begin
                    byte_t e;
                    e = exp_q.pop_front();
                    chk("tx_byte", 32'(tx_data), 32'(e.b));
                    if (e.kind == 1)
                        chk("reg_index", 32'(reg_num), 32'(e.idx));
                    if (e.kind == 3)
                        chk("mem_addr", mem_addr, 32'(e.idx * 4));
                end
                cur_byte = tx_data;
            end else if (tx_ready) begin
                chk("tx_hold", 32'(tx_data), 32'(cur_byte));
            end
            if (ready_prev && done_prev)
                chk("tx_drop", 32'(tx_ready), 32'd0);
            if (step) begin
                step_cycles++;
                chk("step_single", 32'(step_prev), 32'd0);
            end
            if (we) begin
                write_count++;
                chk("we_single", 32'(we_prev), 32'd0);
                if (wr_q.size() == 0) begin
                    checks++;
                    $display("FAIL extra_write: got %h expected none", instr_addr);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", instr_addr, w.a);
                    chk("wr_data", instr_data, w.d);
                end
            end
        end
        ready_prev = rst_n && tx_ready;
        tx_done    = done_hold ? 1'b1 : (rst_n && tx_ready);
        done_prev  = rst_n && tx_done;
        step_prev  = step;
        we_prev    = we;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] w [4];
        rst_n    = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h44;
        pc       = '0;
        alu      = ALU;
        repeat (2) @(negedge clk);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_reg_num", 32'(reg_num), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_step", 32'(step), 32'd0);
            chk("idle_tx_ready", 32'(tx_ready), 32'd0);
        end
        send_byte(8'h44, 1);
        chk("ignored_cmd", 32'(step_cycles), 32'd0);

        // Dump 1: PC valid only during the step pulse, handshake by pulses
        step_cycles = 0;
        bytes_seen  = 0;
        build_dump(32'h1BA5_E93F);
        @(negedge clk);
        rx_data  = 8'h73;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("step_high", 32'(step), 32'd1);
        pc = 32'h1BA5_E93F;
        @(negedge clk);
        chk("step_low", 32'(step), 32'd0);
        chk("first_tx_ready", 32'(tx_ready), 32'd1);
        chk("first_tx_byte", 32'(tx_data), 32'h1B);
        pc = 32'hDEAD_BEEF;
        for (int c = 0; c < 50 && bytes_seen < 4; c++) @(negedge clk);
        done_hold = 1'b1;
        send_byte(8'h73, 1);
        send_byte(8'h69, 1);
        wait_dump(3000);
        chk("pc_word", first_word, 32'h1BA5_E93F);
        chk("dump_bytes", 32'(bytes_seen), 32'd200);
        chk("dump_steps", 32'(step_cycles), 32'd1);
        chk("end_reg_num", 32'(reg_num), 32'd0);
        chk("end_mem_addr", mem_addr, 32'd0);
        chk("end_tx_ready", 32'(tx_ready), 32'd0);
        chk("dump_no_write", 32'(write_count), 32'd0);
        done_hold = 1'b0;

        // Program load: four words then HALT; one byte with a long ready level
        send_byte(8'h69, 1);
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            if (w[i] == HALT) w[i] = 32'h0;
            wr_q.push_back('{32'(i * 4), w[i]});
            for (int k = 3; k >= 0; k--)
                send_byte(w[i][8*k +: 8], (i == 1 && k == 2) ? 3 : 1);
        end
        wr_q.push_back('{32'd16, HALT});
        repeat (4) send_byte(8'hFF, 1);
        repeat (4) send_byte(8'h01, 1);
        repeat (2) @(negedge clk);
        chk("load_writes", 32'(write_count), 32'd5);
        chk("load_pending", 32'(wr_q.size()), 32'd0);
        chk("hold_addr", instr_addr, 32'd16);
        chk("hold_data", instr_data, HALT);
        chk("load_no_step", 32'(step_cycles), 32'd1);

        // Reset in the middle of a dump, then restart from the PC
        pc          = 32'h0BAD_F00D;
        done_hold   = 1'b1;
        step_cycles = 0;
        bytes_seen  = 0;
        build_dump(pc);
        send_byte(8'h73, 1);
        for (int c = 0; c < 500 && bytes_seen < 60; c++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_tx_ready", 32'(tx_ready), 32'd0);
        chk("abort_tx_data", 32'(tx_data), 32'd0);
        chk("abort_step", 32'(step), 32'd0);
        chk("abort_reg_num", 32'(reg_num), 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        chk("abort_we", 32'(we), 32'd0);
        chk("abort_instr_addr", instr_addr, 32'd0);
        chk("abort_instr_data", instr_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step_cycles = 0;
        bytes_seen  = 0;
        first_word  = '0;
        build_dump(pc);
        send_byte(8'h73, 1);
        wait_dump(3000);
        chk("restart_pc", first_word, 32'h0BAD_F00D);
        chk("restart_bytes", 32'(bytes_seen), 32'd200);
        chk("restart_steps", 32'(step_cycles), 32'd1);
        chk("restart_tx_ready", 32'(tx_ready), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
